axil_ram_ctrl_multi: RTL and testbench

- Next-generation PL RAM controller: AXI4-Lite slave fronting a parametrised register-file RAM of DEPTH words × DATA_WIDTH bits.
- Adds what the 4-register generation lacks: byte strobes, independent AW/W acceptance, out-of-range error response, and a write-notification sideband for PL logic.
- Sits behind the PS/AXI interconnect in the block design; the PL consumes the sideband.

---
 rtl/axil_ram_ctrl_pkg.sv | 27 ++
 rtl/axil_ram_ctrl_mem.sv | 40 ++++
 rtl/axil_ram_ctrl_multi.sv | 163 ++++++++++++++++
 tb/tb_axil_ram_ctrl_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ram_ctrl_pkg.sv
// rtl/axil_ram_ctrl_pkg.sv - shared response codes, FSM state types and helpers for the AXI-Lite RAM controller
package axil_ram_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Ceiling log2, never below 1 so index ports stay at least one bit wide.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axil_ram_ctrl_mem.sv
// rtl/axil_ram_ctrl_mem.sv - register-file RAM with byte-strobe write, registered read and async clear
module axil_ram_ctrl_mem
  import axil_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_en,
  input  logic                    rd_zero,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read and write share one edge; the read samples the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      if (rd_en) rd_data <= rd_zero ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/axil_ram_ctrl_multi.sv
// rtl/axil_ram_ctrl_multi.sv - AXI4-Lite RAM controller top with write sideband
// Define AXIL_RAM_CTRL_ADDR_WRAP_EN to wrap out-of-range addresses instead of returning SLVERR.
module axil_ram_ctrl_multi
  import axil_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              mem_wr_pulse,
  output logic [clog2_min1(DEPTH)-1:0]      mem_wr_index
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = clog2_min1(STRB_W);
  localparam int IDX_W  = clog2_min1(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  // Returns {error, index} for a byte address.
  function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = addr >> LSB;
`ifdef AXIL_RAM_CTRL_ADDR_WRAP_EN
    return {1'b0, IDX_W'(word % DEPTH_A)};
`else
    return {(word >= DEPTH_A), word[IDX_W-1:0]};
`endif
  endfunction

  w_state_t w_state;
  r_state_t r_state;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, commit, mem_we;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;
  logic [IDX_W:0]        wr_dec, rd_dec;
  logic                  wr_err;
  logic [IDX_W-1:0]      wr_idx;

  assign S_AXI_AWREADY = ~ARESET & ((w_state == W_IDLE) | (w_state == W_WAIT_AW));
  assign S_AXI_WREADY  = ~ARESET & ((w_state == W_IDLE) | (w_state == W_WAIT_W));
  assign S_AXI_ARREADY = ~ARESET & (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Whichever half arrives on the committing edge comes straight from the bus; the other from its latch.
  always_comb begin
    commit  = ((w_state == W_IDLE) & aw_hs & w_hs) |
              ((w_state == W_WAIT_W) & w_hs) |
              ((w_state == W_WAIT_AW) & aw_hs);
    cm_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    cm_data = w_hs ? S_AXI_WDATA : w_data_q;
    cm_strb = w_hs ? S_AXI_WSTRB : w_strb_q;
    wr_dec  = decode(cm_addr);
    wr_err  = wr_dec[IDX_W];
    wr_idx  = wr_dec[IDX_W-1:0];
    mem_we  = commit & ~wr_err & (|cm_strb);
    rd_dec  = decode(S_AXI_ARADDR);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state      <= W_IDLE;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
      mem_wr_pulse <= 1'b0;
      mem_wr_index <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      mem_wr_pulse <= mem_we;
      if (mem_we) mem_wr_index <= wr_idx;
      if (commit) begin
        w_state     <= W_RESP;
        S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs)     w_state <= W_WAIT_W;
            else if (w_hs) w_state <= W_WAIT_AW;
          end
          W_RESP:  if (S_AXI_BREADY) w_state <= W_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= R_IDLE;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state     <= R_DATA;
            S_AXI_RRESP <= rd_dec[IDX_W] ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA:  if (S_AXI_RREADY) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axil_ram_ctrl_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (ACLK),
    .rst     (ARESET),
    .wr_en   (mem_we),
    .wr_idx  (wr_idx),
    .wr_data (cm_data),
    .wr_strb (cm_strb),
    .rd_en   (ar_hs),
    .rd_zero (rd_dec[IDX_W]),
    .rd_idx  (rd_dec[IDX_W-1:0]),
    .rd_data (S_AXI_RDATA)
  );

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                       S_AXI_ARADDR[LSB-1:0], aw_addr_q[LSB-1:0]};

endmodule

// File: tb/tb_axil_ram_ctrl_multi.sv
// tb/tb_axil_ram_ctrl_multi.sv - directed self-checking bench for axil_ram_ctrl_multi
module tb_axil_ram_ctrl_multi;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        mem_wr_pulse;
  logic [3:0]  mem_wr_index;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [3:0] pulse_idx [$];

  always #5 aclk = ~aclk;

  axil_ram_ctrl_multi #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(8)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .mem_wr_pulse(mem_wr_pulse), .mem_wr_index(mem_wr_index)
  );

  always @(negedge aclk) begin
    if (mem_wr_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_idx.push_back(mem_wr_index);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // order 0: AW and W together, 1: AW three cycles ahead of W, 2: W three cycles ahead of AW
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, output logic [1:0] resp);
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    if (order != 2) awvalid = 1'b1;
    if (order != 1) wvalid = 1'b1;
    step();
    if (order == 1) begin
      awvalid = 1'b0;
      checks++; if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL wait_w_ready got aw=%b w=%b want aw=0 w=1", awready, wready); end
      step(); step();
      wvalid = 1'b1;
      step();
    end else if (order == 2) begin
      wvalid = 1'b0;
      checks++; if (wready !== 1'b0 || awready !== 1'b1) begin errors++; $display("FAIL wait_aw_ready got aw=%b w=%b want aw=1 w=0", awready, wready); end
      step(); step();
      awvalid = 1'b1;
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency got %b want 1 addr %h", bvalid, addr); end
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rvalid_latency got %b want 1 addr %h", rvalid, addr); end
    data = rdata; resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    step(); step();
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid, mem_wr_pulse} !== 3'b000) begin errors++; $display("FAIL reset_valid got %b want 000", {bvalid, rvalid, mem_wr_pulse}); end
    checks++; if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 || mem_wr_index !== 4'h0) begin errors++; $display("FAIL reset_payload got %h %h %h %h want 0", bresp, rresp, rdata, mem_wr_index); end
    areset = 1'b0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL post_reset_ready got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    logic [1:0] resp;
    logic [31:0] d;
    pulse_cnt = 0;
    pulse_idx.delete();
    for (int i = 0; i < 4; i++) begin
      do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, resp);
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp got %h want 0", resp); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(8'(i * 4), d, resp);
      checks++; if (d !== 32'(i + 1) || resp !== 2'b00) begin errors++; $display("FAIL basic_read got %h/%h want %h/0", d, resp, 32'(i + 1)); end
    end
    checks++; if (pulse_cnt !== 4) begin errors++; $display("FAIL basic_pulse_count got %0d want 4", pulse_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= pulse_idx.size() || pulse_idx[i] !== 4'(i)) begin errors++; $display("FAIL basic_pulse_index slot %0d want %0d", i, i); end
    end
  endtask

  task automatic test_order();
    logic [1:0] resp;
    logic [31:0] d;
    do_write(8'h10, 32'hCAFEF00D, 4'hF, 1, resp);
    do_read(8'h10, d, resp);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL aw_first_read got %h want cafef00d", d); end
    do_write(8'h10, 32'h5EED1234, 4'hF, 2, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL w_first_bresp got %h want 0", resp); end
    do_read(8'h10, d, resp);
    checks++; if (d !== 32'h5EED1234) begin errors++; $display("FAIL w_first_read got %h want 5eed1234", d); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [31:0] d;
    int cnt0;
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, resp);
    do_write(8'h08, 32'h11223344, 4'b0101, 0, resp);
    do_read(8'h08, d, resp);
    checks++; if (d !== 32'hFF22FF44) begin errors++; $display("FAIL strobe_merge got %h want ff22ff44", d); end
    cnt0 = pulse_cnt;
    do_write(8'h08, 32'h00000000, 4'b0000, 0, resp);
    checks++; if (resp !== 2'b00 || pulse_cnt !== cnt0) begin errors++; $display("FAIL zero_strobe got resp %h pulses %0d want 0 %0d", resp, pulse_cnt, cnt0); end
    do_read(8'h08, d, resp);
    checks++; if (d !== 32'hFF22FF44) begin errors++; $display("FAIL zero_strobe_data got %h want ff22ff44", d); end
  endtask

  task automatic test_range();
    logic [1:0] resp;
    logic [31:0] d;
    int cnt0;
    do_write(8'h3C, 32'h0F0F0F0F, 4'hF, 0, resp);
    do_read(8'h3F, d, resp);
    checks++; if (d !== 32'h0F0F0F0F || resp !== 2'b00) begin errors++; $display("FAIL last_word got %h/%h want 0f0f0f0f/0", d, resp); end
    cnt0 = pulse_cnt;
    do_write(8'h40, 32'hA5A5A5A5, 4'hF, 0, resp);
`ifdef AXIL_RAM_CTRL_ADDR_WRAP_EN
    checks++; if (resp !== 2'b00 || pulse_cnt !== cnt0 + 1) begin errors++; $display("FAIL wrap_write got %h/%0d want 0/%0d", resp, pulse_cnt, cnt0 + 1); end
    do_read(8'h00, d, resp);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_word0 got %h want a5a5a5a5", d); end
    do_read(8'h40, d, resp);
    checks++; if (d !== 32'hA5A5A5A5 || resp !== 2'b00) begin errors++; $display("FAIL wrap_read got %h/%h want a5a5a5a5/0", d, resp); end
`else
    checks++; if (resp !== 2'b10 || pulse_cnt !== cnt0) begin errors++; $display("FAIL oob_write got %h/%0d want 2/%0d", resp, pulse_cnt, cnt0); end
    do_read(8'h00, d, resp);
    checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL oob_word0 got %h want 00000001", d); end
    do_read(8'h40, d, resp);
    checks++; if (d !== 32'h0 || resp !== 2'b10) begin errors++; $display("FAIL oob_read got %h/%h want 0/2", d, resp); end
`endif
  endtask

  task automatic test_stall();
    logic [1:0] resp;
    logic [31:0] d;
    awaddr = 8'h18; wdata = 32'h0BADCAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    awaddr = 8'h20; wdata = 32'hDEADDEAD; araddr = 8'h20;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL stall_b cycle %0d got %b/%h want 1/0", k, bvalid, bresp); end
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h2 || rresp !== 2'b00) begin errors++; $display("FAIL stall_r cycle %0d got %b/%h/%h want 1/2/0", k, rvalid, rdata, rresp); end
      checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL stall_ready cycle %0d got %b want 000", k, {awready, wready, arready}); end
      step();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL stall_release got %b want 00", {bvalid, rvalid}); end
    do_read(8'h18, d, resp);
    checks++; if (d !== 32'h0BADCAFE) begin errors++; $display("FAIL stall_write_data got %h want 0badcafe", d); end
    do_read(8'h20, d, resp);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL stall_no_extra_write got %h want 0", d); end
  endtask

  task automatic test_collision();
    logic [1:0] resp;
    logic [31:0] d;
    do_write(8'h1C, 32'h11111111, 4'hF, 0, resp);
    awaddr = 8'h1C; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h1C; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h11111111) begin errors++; $display("FAIL collision_old got %b/%h want 1/11111111", rvalid, rdata); end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    do_read(8'h1C, d, resp);
    checks++; if (d !== 32'h22222222) begin errors++; $display("FAIL collision_new got %h want 22222222", d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [31:0] d;
    int cnt0;
    cnt0 = pulse_cnt;
    awaddr = 8'h00; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL mid_wait_w got aw=%b w=%b want 0/1", awready, wready); end
    areset = 1'b1;
    #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_outputs got %b/%h want 0", {awready, wready, arready, bvalid, rvalid}, rdata); end
    step();
    areset = 1'b0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL mid_post_ready got %b want 111", {awready, wready, arready}); end
    step();
    checks++; if (bvalid !== 1'b0 || pulse_cnt !== cnt0) begin errors++; $display("FAIL mid_no_commit got %b/%0d want 0/%0d", bvalid, pulse_cnt, cnt0); end
    do_read(8'h00, d, resp);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_cleared_w0 got %h want 0", d); end
    do_read(8'h10, d, resp);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_cleared_w4 got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_strobe();
    test_range();
    test_stall();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
